// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue/sequencer stage in front of an 8-bit combinational ALU.
// Accepts one operation over an input valid/ready handshake, registers it onto
// the ALU inputs, waits SETTLE_CYCLES, captures R/F and offers them over an
// output valid/ready handshake. Counts completed output handshakes.
//
// Optional feature macro: ACC_FORWARD_EN
//   defined   -> accumulator holds the last handed-off result; in_use_acc=1 on
//                accept selects it as operand A.
//   undefined -> no accumulator, in_use_acc is ignored.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. The valid side keeps valid and payload stable
// until that edge; ready may change freely and never depends on valid.
//
// dbg_state exposes the FSM encoding: 0=IDLE 1=SETTLE 2=CAPTURE 3=HOLD.
module alu_issue_unit #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [3:0]       in_op,
    input  logic             in_use_acc,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [7:0]       alu_r,
    input  logic [2:0]       alu_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_r,
    output logic [2:0]       out_f,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("alu_issue_unit: SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_settle;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [3:0]       r_alu_op;
    logic [7:0]       r_out_r;
    logic [2:0]       r_out_f;
    logic [CNT_W-1:0] r_op_count;
    logic             w_accept;
    logic             w_out_fire;
    logic [7:0]       w_a_src;

    // in_ready is low while reset is asserted even though the state is already IDLE.
    assign in_ready   = (r_state == S_IDLE) && rst_n;
    assign out_valid  = (r_state == S_HOLD);
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign out_r     = r_out_r;
    assign out_f     = r_out_f;
    assign op_count  = r_op_count;
    assign dbg_state = r_state;

`ifdef ACC_FORWARD_EN
    logic [7:0] r_acc;

    // Accumulator remembers the result of the most recent output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= 8'h00;
        end else if (w_out_fire) begin
            r_acc <= r_out_r;
        end
    end

    assign w_a_src = in_use_acc ? r_acc : in_a;
`else
    logic w_unused_use_acc;
    assign w_unused_use_acc = in_use_acc;
    assign w_a_src          = in_a;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next_state = S_SETTLE;
            S_SETTLE:  if (r_settle == 4'd1) w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_HOLD;
            S_HOLD:    if (out_ready) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Operand registers change only on accept; settle counter runs during SETTLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a  <= 8'h00;
            r_alu_b  <= 8'h00;
            r_alu_op <= 4'h0;
            r_settle <= 4'd0;
        end else if (w_accept) begin
            r_alu_a  <= w_a_src;
            r_alu_b  <= in_b;
            r_alu_op <= in_op;
            r_settle <= 4'(SETTLE_CYCLES);
        end else if (r_state == S_SETTLE) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    // Result capture at the CAPTURE edge; held untouched through HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_r <= 8'h00;
            r_out_f <= 3'b000;
        end else if (r_state == S_CAPTURE) begin
            r_out_r <= alu_r;
            r_out_f <= alu_f;
        end
    end

    // Completed-operation counter, wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_out_fire) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: main instance (SETTLE_CYCLES=1, CNT_W=4) checked
// through a result scoreboard, second instance (SETTLE_CYCLES=4) for latency
// and mid-operation reset. ALU stub: R = A + B, F = OP[2:0].
module tb_alu_issue_unit;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rst4_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic       in_valid, in_ready, in_use_acc;
    logic [7:0] in_a, in_b;
    logic [3:0] in_op;
    logic [7:0] alu_a, alu_b, alu_r;
    logic [3:0] alu_op;
    logic [2:0] alu_f;
    logic       out_valid, out_ready;
    logic [7:0] out_r;
    logic [2:0] out_f;
    logic [3:0] op_count;
    logic [1:0] dbg_state;

    assign alu_r = alu_a + alu_b;
    assign alu_f = alu_op[2:0];

    alu_issue_unit #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_f(alu_f),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_f(out_f),
        .op_count(op_count), .dbg_state(dbg_state)
    );

    // ---------------- second DUT (SETTLE_CYCLES=4) ----------------
    logic        in_valid4, in_ready4;
    logic [7:0]  in_a4, in_b4;
    logic [3:0]  in_op4;
    logic [7:0]  alu_a4, alu_b4, alu_r4;
    logic [3:0]  alu_op4;
    logic [2:0]  alu_f4;
    logic        out_valid4, out_ready4;
    logic [7:0]  out_r4;
    logic [2:0]  out_f4;
    logic [15:0] op_count4;
    logic [1:0]  dbg_state4;

    assign alu_r4 = alu_a4 + alu_b4;
    assign alu_f4 = alu_op4[2:0];

    alu_issue_unit #(.SETTLE_CYCLES(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst4_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_op(in_op4), .in_use_acc(1'b0),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
        .alu_r(alu_r4), .alu_f(alu_f4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_r(out_r4), .out_f(out_f4),
        .op_count(op_count4), .dbg_state(dbg_state4)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_item;
    logic [7:0]  acc_m    = 8'h00;
    int          exp_cnt  = 0;
    logic [7:0]  last_a_eff;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output handshake monitor: compare each delivered result against the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_item = exp_q.pop_front();
                check("sb_out_r", 32'(out_r), 32'(exp_item[10:3]));
                check("sb_out_f", 32'(out_f), 32'(exp_item[2:0]));
                acc_m   = exp_item[10:3];
                exp_cnt = exp_cnt + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!(in_ready && exp_q.size() == 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("done_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Presents one op at a negedge with in_ready high, so it is accepted at the next posedge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic use_acc);
        logic [7:0] a_eff;
        wait_ready();
        in_a       = a;
        in_b       = b;
        in_op      = op;
        in_use_acc = use_acc;
        in_valid   = 1'b1;
`ifdef ACC_FORWARD_EN
        a_eff = use_acc ? acc_m : a;
`else
        a_eff = a;
`endif
        last_a_eff = a_eff;
        exp_q.push_back({8'(a_eff + b), op[2:0]});
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        rst_n = 1'b0; rst4_n = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 4'h0; in_use_acc = 1'b0;
        out_ready = 1'b1;
        in_valid4 = 1'b0; in_a4 = 8'h00; in_b4 = 8'h00; in_op4 = 4'h0; out_ready4 = 1'b1;

        // Reset: three edges low, checks during reset, then release.
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_state", 32'(dbg_state), 32'd0);

        // Basic op: 0F + 0F, op 1, out_ready held high.
        do_op(8'h0F, 8'h0F, 4'b0001, 1'b0);
        @(negedge clk);
        check("basic_alu_a", 32'(alu_a), 32'h0F);
        check("basic_alu_b", 32'(alu_b), 32'h0F);
        check("basic_alu_op", 32'(alu_op), 32'h1);
        check("basic_busy", 32'(in_ready), 32'd0);
        check("basic_ov_n0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("basic_ov_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("basic_ov_n2", 32'(out_valid), 32'd1);
        check("basic_out_r", 32'(out_r), 32'h1E);
        check("basic_out_f", 32'(out_f), 32'h1);
        @(negedge clk);
        check("basic_ov_n3", 32'(out_valid), 32'd0);
        check("basic_count", 32'(op_count), 32'd1);

        // Backpressure: result held stable while out_ready is low.
        out_ready = 1'b0;
        do_op(8'hF0, 8'h20, 4'b0010, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_r", 32'(out_r), 32'h10);
            check("bp_out_f", 32'(out_f), 32'h2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_count", 32'(op_count), 32'd2);

        // Accumulator chain (forwarded A only with ACC_FORWARD_EN).
        do_op(8'h03, 8'h04, 4'b0000, 1'b0);
        wait_done();
        do_op(8'hAA, 8'h01, 4'b0101, 1'b1);
        @(negedge clk);
`ifdef ACC_FORWARD_EN
        check("acc_alu_a", 32'(alu_a), 32'h07);
`else
        check("acc_alu_a", 32'(alu_a), 32'hAA);
`endif
        wait_done();
        check("acc_count", 32'(op_count), 32'd4);

        // Random ops, 12 more -> 16 total -> 4-bit counter wraps to 0.
        for (int i = 0; i < 12; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            check("rnd_alu_a", 32'(alu_a), 32'(last_a_eff));
            wait_done();
            check("rnd_count", 32'(op_count), 32'(exp_cnt % 16));
        end
        check("wrap_count", 32'(op_count), 32'd0);

        // Second instance: reset while in SETTLE discards the op.
        @(negedge clk);
        in_a4 = 8'h11; in_b4 = 8'h22; in_op4 = 4'h3; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(negedge clk);
        check("mid_in_settle", 32'(dbg_state4), 32'd1);
        @(negedge clk);
        rst4_n = 1'b0;
        @(posedge clk);
        #1;
        rst4_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | out_valid4;
        end
        check("mid_no_valid", 32'(seen), 32'd0);
        check("mid_state_idle", 32'(dbg_state4), 32'd0);
        check("mid_in_ready", 32'(in_ready4), 32'd1);
        check("mid_count", 32'(op_count4), 32'd0);
        check("mid_alu_a", 32'(alu_a4), 32'd0);

        // Second instance: latency with SETTLE_CYCLES=4 (sample at N+5).
        @(negedge clk);
        in_a4 = 8'h40; in_b4 = 8'h02; in_op4 = 4'h6; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("lat4_ov_low", 32'(out_valid4), 32'd0);
        end
        @(negedge clk);
        check("lat4_ov_high", 32'(out_valid4), 32'd1);
        check("lat4_out_r", 32'(out_r4), 32'h42);
        check("lat4_out_f", 32'(out_f4), 32'h6);
        @(negedge clk);
        check("lat4_ov_done", 32'(out_valid4), 32'd0);
        check("lat4_count", 32'(op_count4), 32'd1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
Sequencer stage directly upstream of the 8-bit ALU (A, B, OP[3:0] -> R[7:0], F[2:0]). It accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. After a programmable settle time it captures the ALU's R and F and presents them downstream over a second valid/ready handshake. It also keeps a running count of completed operations.

Parameters:
SETTLE_CYCLES, 1, cycles alu_a/alu_b/alu_op are held stable before R/F are sampled; legal range 1..15.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  upstream presents an operation
in_ready  output  1  unit can accept an operation
in_a  input  8  operand A
in_b  input  8  operand B
in_op  input  4  ALU opcode
in_use_acc  input  1  use last captured result as A (see Optional Feature)
alu_a  output  8  registered operand to ALU A
alu_b  output  8  registered operand to ALU B
alu_op  output  4  registered opcode to ALU OP
alu_r  input  8  ALU result R
alu_f  input  3  ALU flags F
out_valid  output  1  captured result available
out_ready  input  1  downstream accepts result
out_r  output  8  captured result
out_f  output  3  captured flags
op_count  output  CNT_W  number of completed output handshakes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Reset values (rst_n=0 at a rising edge): state=IDLE; in_ready=0 during the reset cycle, 1 from the first cycle after release; alu_a=alu_b=0, alu_op=4'b0000; out_valid=0, out_r=0, out_f=0; op_count=0; settle counter=0; accumulator=0.
- Reset mid-operation: any state returns to IDLE and the in-flight operation is discarded; no output handshake occurs for it.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_a/in_b/in_op onto alu_a/alu_b/alu_op, load settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: in_ready=0. Decrement the counter each cycle. When the counter reaches 1, go to CAPTURE.
  - CAPTURE: in_ready=0. Sample alu_r->out_r and alu_f->out_f at this edge, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1, out_r/out_f stable. On out_valid&&out_ready: out_valid=0, op_count+=1, go to IDLE.
- alu_a/alu_b/alu_op keep their values after the operation until the next accept. They change only on an accept or on reset.
- Latency with out_ready held at 1, accept at edge N:
  - alu_* valid after edge N;
  - sample at edge N+SETTLE_CYCLES+1;
  - out_valid high after that edge;
  - handshake completes at the next edge.
- Throughput: one operation per SETTLE_CYCLES+3 cycles.
- in_ready is a pure state decode (IDLE only). An in_valid asserted outside IDLE is ignored; the upstream must hold it.
- out_valid, once asserted, stays asserted and out_r/out_f stay stable until the handshake completes, regardless of out_ready.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- SETTLE_CYCLES outside 1..15 is an elaboration error.

Optional Feature:
Macro ACC_FORWARD_EN.
- Defined:
  - An internal accumulator register loads out_r at each output handshake; reset value 0.
  - On accept with in_use_acc=1, alu_a is loaded from the accumulator instead of in_a. This allows chained operations without an external round trip.
- Not defined:
  - No accumulator is built.
  - in_use_acc is ignored and alu_a always loads from in_a.

Test Plan:
- The bench ALU stub drives alu_r = alu_a + alu_b (mod 256) and alu_f = {alu_op[2:0]} in all scenarios.
- Reset release: hold rst_n=0 for 3 cycles, then 1 -> in_ready=0 during reset and 1 after; out_valid=0; op_count=0; alu_a=alu_b=0; alu_op=0.
- Basic op, SETTLE_CYCLES=1, out_ready=1: in_a=8'h0F, in_b=8'h0F, in_op=4'b0001 -> alu_a=8'h0F, alu_b=8'h0F the cycle after accept; out_valid 2 cycles after accept with out_r=8'h1E, out_f=3'b001; op_count=1.
- Backpressure: in_a=8'hF0, in_b=8'h20, op=4'b0010, out_ready=0 for 5 cycles -> out_valid held with out_r=8'h10 and out_f=3'b010 stable; in_ready=0 throughout; handshake on the first out_ready=1; op_count increments by exactly 1.
- Reset mid-operation: assert rst_n=0 while in SETTLE with SETTLE_CYCLES=4 -> no out_valid pulse; state is IDLE and op_count unchanged after release.
- Counter wrap (CNT_W=4): run 16 operations -> op_count returns to 0.
- ACC_FORWARD_EN defined: op1 A=8'h03, B=8'h04 -> out_r=8'h07; op2 in_use_acc=1, in_a=8'hAA, B=8'h01 -> alu_a=8'h07, out_r=8'h08. With the macro undefined, op2 gives alu_a=8'hAA and out_r=8'hAB.
